// File: rtl/rom_loader_if.sv
// Flash-read and SRAM-write bus used by the boot-time ROM loader.
// The loader is the master. The flash reader and SRAM mux side is the slave.
interface rom_loader_if;
  logic        flash_rden;
  logic        flash_read;
  logic [23:0] flash_addr;
  logic [7:0]  flash_data;
  logic        flash_valid;
  logic [16:0] ram_addr;
  logic [7:0]  ram_data;
  logic        ram_wren;

  modport master (
    output flash_rden,
    output flash_read,
    output flash_addr,
    input  flash_data,
    input  flash_valid,
    output ram_addr,
    output ram_data,
    output ram_wren
  );

  modport slave (
    input  flash_rden,
    input  flash_read,
    input  flash_addr,
    output flash_data,
    output flash_valid,
    input  ram_addr,
    input  ram_data,
    input  ram_wren
  );
endinterface

// File: rtl/rom_loader.sv
// Boot-time copier: streams ROM image bytes from configuration flash into the
// low 128K of SRAM. It owns the SRAM bus while busy. A byte whose flash read
// times out is re-requested a bounded number of times before the load aborts.
module rom_loader #(
  parameter logic [23:0] ROM_OFFSET = 24'h013256,
  parameter logic [16:0] LOAD_SIZE  = 17'h1FFFF,
  parameter int unsigned WR_CYCLES  = 2,
  parameter int unsigned TIMEOUT    = 255,
  parameter int unsigned MAX_RETRY  = 3
) (
  input  logic         clk28,
  input  logic         rst_n,
  input  logic         start,
  rom_loader_if.master bus,
  output logic         busy,
  output logic         done,
  output logic         error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_SETUP,
    S_WRITE,
    S_HOLD,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [2:0] WR_LAST   = 3'(WR_CYCLES - 1);
  localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT);
  localparam logic [1:0] RETRY_MAX = 2'(MAX_RETRY);

  state_t      state_q, state_d;
  logic [16:0] idx_q, idx_d;
  logic [1:0]  retry_q, retry_d;
  logic [7:0]  tmo_q, tmo_d;
  logic [2:0]  wr_cnt_q, wr_cnt_d;
  logic [7:0]  byte_q, byte_d;
  logic        flash_read_q, flash_read_d;
  logic [23:0] flash_addr_q, flash_addr_d;
  logic [16:0] ram_addr_q, ram_addr_d;
  logic [7:0]  ram_data_q, ram_data_d;
  logic        ram_wren_q, ram_wren_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  // Next-state and next-output logic; outputs are decoded from the next state so they line up with it once registered
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    retry_d      = retry_q;
    tmo_d        = tmo_q;
    wr_cnt_d     = wr_cnt_q;
    byte_d       = byte_q;
    flash_addr_d = flash_addr_q;
    ram_addr_d   = ram_addr_q;
    ram_data_d   = ram_data_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        tmo_d   = 8'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.flash_valid) begin
          byte_d  = bus.flash_data;
          retry_d = 2'd0;
          state_d = S_SETUP;
        end else if (tmo_q == TMO_LAST) begin
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + 2'd1;
            state_d = S_REQ;
          end else begin
            state_d = S_ERROR;
          end
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      S_SETUP: begin
        wr_cnt_d = 3'd0;
        state_d  = S_WRITE;
      end
      S_WRITE: begin
        if (wr_cnt_q == WR_LAST) begin
          state_d = S_HOLD;
        end else begin
          wr_cnt_d = wr_cnt_q + 3'd1;
        end
      end
      S_HOLD: begin
        if (idx_q == LOAD_SIZE) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 17'd1;
          state_d = S_REQ;
        end
      end
      S_DONE:  state_d = S_DONE;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_IDLE;
    endcase

    flash_read_d = (state_d == S_REQ);
    if (state_d == S_REQ) begin
      flash_addr_d = ROM_OFFSET + {7'b0, idx_d};
    end
    if (state_d == S_SETUP) begin
      ram_addr_d = idx_d;
      ram_data_d = byte_d;
    end
    ram_wren_d = (state_d == S_WRITE);
    busy_d     = !((state_d == S_IDLE) || (state_d == S_DONE) || (state_d == S_ERROR));
    done_d     = (state_d == S_DONE);
    error_d    = (state_d == S_ERROR);
  end

  // State and registered outputs; async reset drops every output, including an in-flight write pulse
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      idx_q        <= 17'd0;
      retry_q      <= 2'd0;
      tmo_q        <= 8'd0;
      wr_cnt_q     <= 3'd0;
      byte_q       <= 8'd0;
      flash_read_q <= 1'b0;
      flash_addr_q <= 24'd0;
      ram_addr_q   <= 17'd0;
      ram_data_q   <= 8'd0;
      ram_wren_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      retry_q      <= retry_d;
      tmo_q        <= tmo_d;
      wr_cnt_q     <= wr_cnt_d;
      byte_q       <= byte_d;
      flash_read_q <= flash_read_d;
      flash_addr_q <= flash_addr_d;
      ram_addr_q   <= ram_addr_d;
      ram_data_q   <= ram_data_d;
      ram_wren_q   <= ram_wren_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign bus.flash_rden = busy_q;
  assign bus.flash_read = flash_read_q;
  assign bus.flash_addr = flash_addr_q;
  assign bus.ram_addr   = ram_addr_q;
  assign bus.ram_data   = ram_data_q;
  assign bus.ram_wren   = ram_wren_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader with a 4-byte image (LOAD_SIZE=3).
// A flash model answers reads with addr[7:0] after 4 cycles, optionally dropping
// responses, and an SRAM model records writes and write-pulse shapes.
module tb_rom_loader;

  logic clk28;
  logic rst_n;
  logic start;
  logic busy;
  logic done;
  logic error;

  rom_loader_if bus ();

  rom_loader #(
    .LOAD_SIZE (17'd3)
  ) dut (
    .clk28 (clk28),
    .rst_n (rst_n),
    .start (start),
    .bus   (bus.master),
    .busy  (busy),
    .done  (done),
    .error (error)
  );

  int total = 0;
  int bad   = 0;

  int          cyc = 0;
  int          mode = 0;
  logic        dropped;
  int          pend_cnt;
  logic [23:0] pend_addr;
  logic [23:0] rd_addr[$];
  int          rd_cyc[$];

  logic [7:0]  mem [0:15];
  logic        prev_wren;
  logic [16:0] prev_addr;
  logic [7:0]  prev_data;
  int          run_len;
  int          widths[$];
  int          stab_err;
  int          wren_total;

  // Free-running clock, about 28 MHz scale is irrelevant here
  initial clk28 = 1'b0;
  always #5 clk28 = ~clk28;

  // Cycle counter used to time flash read strobes
  always @(posedge clk28) cyc <= cyc + 1;

  // Flash model: logs each read strobe and answers with addr[7:0] four cycles later unless the mode drops it
  always @(negedge clk28) begin
    if (!rst_n) begin
      pend_cnt         = 0;
      pend_addr        = 24'd0;
      dropped          = 1'b0;
      bus.flash_valid  = 1'b0;
      bus.flash_data   = 8'd0;
      rd_addr.delete();
      rd_cyc.delete();
    end else begin
      bus.flash_valid = 1'b0;
      if (pend_cnt > 0) begin
        pend_cnt = pend_cnt - 1;
        if (pend_cnt == 0) begin
          bus.flash_valid = 1'b1;
          bus.flash_data  = pend_addr[7:0];
        end
      end
      if (bus.flash_read) begin
        rd_addr.push_back(bus.flash_addr);
        rd_cyc.push_back(cyc);
        if (mode == 2 && bus.flash_addr == 24'h013256) begin
          pend_cnt = 0;
        end else if (mode == 1 && bus.flash_addr == 24'h013257 && !dropped) begin
          dropped  = 1'b1;
          pend_cnt = 0;
        end else begin
          pend_cnt  = 4;
          pend_addr = bus.flash_addr;
        end
      end
    end
  end

  // SRAM model: stores written bytes, measures write pulse widths and checks address/data stability around them
  always @(negedge clk28) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) mem[i] = 8'hEE;
      prev_wren  = 1'b0;
      prev_addr  = 17'd0;
      prev_data  = 8'd0;
      run_len    = 0;
      stab_err   = 0;
      wren_total = 0;
      widths.delete();
    end else begin
      if (bus.ram_wren) begin
        mem[bus.ram_addr[3:0]] = bus.ram_data;
        wren_total = wren_total + 1;
        run_len    = run_len + 1;
        if (bus.ram_addr !== prev_addr || bus.ram_data !== prev_data) stab_err = stab_err + 1;
      end else if (prev_wren) begin
        widths.push_back(run_len);
        run_len = 0;
        if (bus.ram_addr !== prev_addr || bus.ram_data !== prev_data) stab_err = stab_err + 1;
      end
      prev_wren = bus.ram_wren;
      prev_addr = bus.ram_addr;
      prev_data = bus.ram_data;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input int n);
    @(negedge clk28);
    start = s;
    repeat (n) @(negedge clk28);
  endtask

  task automatic doReset(input logic s);
    @(negedge clk28);
    rst_n = 1'b0;
    start = s;
    repeat (3) @(negedge clk28);
    rst_n = 1'b1;
  endtask

  task automatic waitIdle(input string tag, input int max_cycles);
    int i;
    i = 0;
    repeat (2) @(negedge clk28);
    while (busy && i < max_cycles) begin
      @(negedge clk28);
      i++;
    end
    checkOutput(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    int n57;
    int c57[$];
    int i;

    rst_n = 1'b0;
    start = 1'b0;

    // Reset values
    $display("[TB] reset values");
    doReset(1'b0);
    repeat (100) @(negedge clk28);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_error", 32'(error), 32'd0);
    checkOutput("rst_rden", 32'(bus.flash_rden), 32'd0);
    checkOutput("rst_wren", 32'(bus.ram_wren), 32'd0);
    checkOutput("rst_faddr", 32'(bus.flash_addr), 32'd0);
    checkOutput("rst_raddr", 32'(bus.ram_addr), 32'd0);
    checkOutput("rst_reads", 32'(rd_addr.size()), 32'd0);

    // Basic copy, with a stray start pulse while busy
    $display("[TB] basic copy");
    mode = 0;
    applyStimulus(1'b1, 1);
    start = 1'b0;
    checkOutput("copy_busy", 32'(busy), 32'd1);
    checkOutput("copy_rden", 32'(bus.flash_rden), 32'd1);
    applyStimulus(1'b0, 20);
    applyStimulus(1'b1, 2);
    start = 1'b0;
    waitIdle("copy_finish", 2000);
    checkOutput("copy_reads", 32'(rd_addr.size()), 32'd4);
    for (int k = 0; k < 4 && k < rd_addr.size(); k++)
      checkOutput($sformatf("copy_faddr%0d", k), 32'(rd_addr[k]), 32'h013256 + 32'(k));
    checkOutput("copy_ram0", 32'(mem[0]), 32'h56);
    checkOutput("copy_ram1", 32'(mem[1]), 32'h57);
    checkOutput("copy_ram2", 32'(mem[2]), 32'h58);
    checkOutput("copy_ram3", 32'(mem[3]), 32'h59);
    checkOutput("copy_pulses", 32'(widths.size()), 32'd4);
    for (int k = 0; k < widths.size(); k++)
      checkOutput($sformatf("copy_width%0d", k), 32'(widths[k]), 32'd2);
    checkOutput("copy_stable", 32'(stab_err), 32'd0);
    checkOutput("copy_done", 32'(done), 32'd1);
    checkOutput("copy_error", 32'(error), 32'd0);
    checkOutput("copy_rden_off", 32'(bus.flash_rden), 32'd0);

    // start toggled after done is ignored
    $display("[TB] start after done");
    for (int k = 0; k < 4; k++) applyStimulus(k[0] ? 1'b0 : 1'b1, 5);
    start = 1'b0;
    repeat (20) @(negedge clk28);
    checkOutput("after_reads", 32'(rd_addr.size()), 32'd4);
    checkOutput("after_raddr", 32'(bus.ram_addr), 32'd3);
    checkOutput("after_busy", 32'(busy), 32'd0);
    checkOutput("after_done", 32'(done), 32'd1);

    // Timeout retry on byte 1
    $display("[TB] timeout retry");
    mode = 1;
    doReset(1'b0);
    applyStimulus(1'b1, 1);
    start = 1'b0;
    waitIdle("retry_finish", 5000);
    n57 = 0;
    for (int k = 0; k < rd_addr.size(); k++) begin
      if (rd_addr[k] == 24'h013257) begin
        n57++;
        c57.push_back(rd_cyc[k]);
      end
    end
    checkOutput("retry_strobes57", 32'(n57), 32'd2);
    if (c57.size() >= 2)
      checkOutput("retry_gap", 32'(c57[1] - c57[0]), 32'd257);
    checkOutput("retry_reads", 32'(rd_addr.size()), 32'd5);
    checkOutput("retry_ram1", 32'(mem[1]), 32'h57);
    checkOutput("retry_ram3", 32'(mem[3]), 32'h59);
    checkOutput("retry_done", 32'(done), 32'd1);
    checkOutput("retry_error", 32'(error), 32'd0);

    // Abort after retries exhausted on byte 0
    $display("[TB] abort");
    mode = 2;
    doReset(1'b0);
    applyStimulus(1'b1, 1);
    start = 1'b0;
    waitIdle("abort_finish", 3000);
    checkOutput("abort_reads", 32'(rd_addr.size()), 32'd4);
    if (rd_addr.size() > 0)
      checkOutput("abort_faddr_last", 32'(rd_addr[rd_addr.size() - 1]), 32'h013256);
    checkOutput("abort_error", 32'(error), 32'd1);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_wren_total", 32'(wren_total), 32'd0);

    // start held high from reset gives exactly one load
    $display("[TB] start held high");
    mode = 0;
    doReset(1'b1);
    waitIdle("held_finish", 2000);
    repeat (50) @(negedge clk28);
    checkOutput("held_reads", 32'(rd_addr.size()), 32'd4);
    checkOutput("held_done", 32'(done), 32'd1);
    checkOutput("held_wren_total", 32'(wren_total), 32'd8);
    start = 1'b0;

    // Reset during a write pulse, then restart
    $display("[TB] reset mid-write");
    doReset(1'b0);
    applyStimulus(1'b1, 1);
    start = 1'b0;
    i = 0;
    while (!bus.ram_wren && i < 500) begin
      @(negedge clk28);
      i++;
    end
    checkOutput("midwr_wren_seen", 32'(bus.ram_wren), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midwr_wren_drop", 32'(bus.ram_wren), 32'd0);
    checkOutput("midwr_busy_drop", 32'(busy), 32'd0);
    repeat (3) @(negedge clk28);
    start = 1'b1;
    rst_n = 1'b1;
    i = 0;
    while (rd_addr.size() == 0 && i < 100) begin
      @(negedge clk28);
      i++;
    end
    start = 1'b0;
    checkOutput("midwr_restart_reads", 32'(rd_addr.size() > 0), 32'd1);
    if (rd_addr.size() > 0)
      checkOutput("midwr_restart_faddr", 32'(rd_addr[0]), 32'h013256);
    waitIdle("midwr_finish", 2000);
    checkOutput("midwr_ram0", 32'(mem[0]), 32'h56);
    checkOutput("midwr_done", 32'(done), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
